// File: rtl/sseg_sched_if.sv
// Bundle of the slot-write and display-output signals of the seven-segment
// display scheduler. The master side (producer/testbench) drives writes and
// clears. The slave side (the scheduler) drives ready and display outputs.
interface sseg_sched_if;
    logic [3:0]  wr_valid;
    logic [63:0] wr_data;
    logic [3:0]  wr_ready;
    logic [3:0]  clr;
    logic [15:0] out_val;
    logic        out_blank;
    logic [1:0]  out_src;
    logic        rot;

    modport master (
        output wr_valid,
        output wr_data,
        output clr,
        input  wr_ready,
        input  out_val,
        input  out_blank,
        input  out_src,
        input  rot
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  clr,
        output wr_ready,
        output out_val,
        output out_blank,
        output out_src,
        output rot
    );
endinterface

// File: rtl/sseg_sched.sv
// Seven-segment display scheduler.
// Four 16-bit slots each carry a valid bit. The scheduler rotates display
// ownership round-robin among the valid slots, showing each owner for HOLD
// cycles. Slot 0 is the alert slot: a write to it preempts any other owner.
module sseg_sched #(
    parameter int HOLD_W = 24,
    parameter int HOLD   = 10000000
) (
    input  logic         clk,
    input  logic         rst_n,
    sseg_sched_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    logic [15:0]       slot_val_q [4];
    logic [15:0]       slot_val_d [4];
    logic [3:0]        slot_vld_q, slot_vld_d;
    logic [0:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [15:0]       out_val_q, out_val_d;
    logic [1:0]        out_src_q, out_src_d;
    logic              out_blank_q, out_blank_d;
    logic              rot_q, rot_d;
    logic              ready_q, ready_d;

    logic [3:0]        acc;
    logic              preempt;
    logic              nxt_found;
    logic [1:0]        nxt_owner;

    // Writes are accepted only once ready has come up after reset
    assign acc     = bus.wr_valid & {4{ready_q}};
    // An alert write steals the display from any other owner
    assign preempt = (state_q == ST_SHOW) && (owner_q != 2'd0) && acc[0];

    // Slot storage: an accepted write wins over a same-cycle clear
    always_comb begin
        slot_vld_d = slot_vld_q;
        for (int i = 0; i < 4; i++) begin
            slot_val_d[i] = slot_val_q[i];
            if (acc[i]) begin
                slot_val_d[i] = bus.wr_data[16*i +: 16];
                slot_vld_d[i] = 1'b1;
            end else if (bus.clr[i]) begin
                slot_vld_d[i] = 1'b0;
            end
        end
    end

    // Round-robin search starting just after the owner, ending on the owner itself
    always_comb begin
        logic [1:0] idx;
        nxt_found = 1'b0;
        nxt_owner = owner_q;
        idx       = owner_q;
        for (int k = 1; k <= 4; k++) begin
            idx = owner_q + 2'(k);
            if (!nxt_found && slot_vld_q[idx]) begin
                nxt_found = 1'b1;
                nxt_owner = idx;
            end
        end
    end

    // Ownership FSM: preempt beats owner-cleared rotation, which beats hold expiry
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|slot_vld_q) begin
                    state_d = ST_SHOW;
                    owner_d = nxt_owner;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (preempt) begin
                    owner_d = 2'd0;
                    cnt_d   = '0;
                end else if (!slot_vld_q[owner_q]) begin
                    cnt_d = '0;
                    if (nxt_found) begin
                        owner_d = nxt_owner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    owner_d = nxt_owner;
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Display outputs follow the owner committed at the same edge; a preempting
    // write is bypassed straight to out_val so the alert shows without a stale cycle
    always_comb begin
        out_val_d   = out_val_q;
        out_src_d   = out_src_q;
        out_blank_d = 1'b1;
        rot_d       = 1'b0;
        ready_d     = 1'b1;
        if (state_d == ST_SHOW) begin
            out_blank_d = 1'b0;
            out_src_d   = owner_d;
            out_val_d   = preempt ? bus.wr_data[15:0] : slot_val_q[owner_d];
            rot_d       = (state_q == ST_IDLE) || (owner_d != owner_q);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot_val_q[i] <= 16'h0000;
            end
            slot_vld_q  <= 4'b0000;
            state_q     <= ST_IDLE;
            owner_q     <= 2'd3;
            cnt_q       <= '0;
            out_val_q   <= 16'h0000;
            out_src_q   <= 2'd0;
            out_blank_q <= 1'b1;
            rot_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                slot_val_q[i] <= slot_val_d[i];
            end
            slot_vld_q  <= slot_vld_d;
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            out_val_q   <= out_val_d;
            out_src_q   <= out_src_d;
            out_blank_q <= out_blank_d;
            rot_q       <= rot_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.wr_ready  = {4{ready_q}};
    assign bus.out_val   = out_val_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_blank = out_blank_q;
    assign bus.rot       = rot_q;

endmodule

// File: doc/sseg_sched.md
SSEG_SCHED -- requirements
Module: sseg_sched

Interface
REQ-001 The module SHALL take parameter HOLD_W, default 24, giving the width of the hold counter.
REQ-002 The module SHALL take parameter HOLD, default 10000000, giving the display cycles per owner (1 s at 10 MHz); legal range 2..2**HOLD_W-1.
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port wr_valid  input  4  per-slot write request, bit i = slot i.
REQ-006 Port wr_data  input  64  per-slot 16-bit value, slot i = bits [16i+15:16i].
REQ-007 Port wr_ready  output  4  per-slot write accept.
REQ-008 Port clr  input  4  per-slot invalidate request.
REQ-009 Port out_val  output  16  value for the 4-digit display driver, msb nibble leftmost.
REQ-010 Port out_blank  output  1  high when no slot is valid; display consumer blanks all digits.
REQ-011 Port out_src  output  2  index of slot currently shown.
REQ-012 Port rot  output  1  one-cycle pulse when the owner changes.

Function
REQ-013 The block SHALL hold four slots, each a 16-bit value register plus a valid bit.
REQ-014 A write SHALL be accepted on an edge where wr_valid[i] and wr_ready[i] are both high; the slot stores wr_data[i] and sets valid.
REQ-015 wr_ready SHALL be 4'b0000 while rst_n is low and 4'b1111 from the first edge after release.
REQ-016 clr[i] SHALL clear valid of slot i at the next edge; the value register is not changed.
REQ-017 When clr[i] and an accepted write to slot i coincide, the write SHALL win (slot valid, new data).
REQ-018 The FSM SHALL have exactly two states: IDLE (no owner) and SHOW (owner register valid).
REQ-019 Next-owner search order SHALL be owner+1, owner+2, owner+3, owner (mod 4); the first slot found valid is selected.
REQ-020 In IDLE, when any slot is valid, the FSM SHALL enter SHOW at the next edge with owner = next-owner, hold counter = 0.
REQ-021 In SHOW, the hold counter SHALL increment every cycle; at HOLD-1 it SHALL return to 0 and owner SHALL take next-owner, which may equal the current owner.
REQ-022 If valid of the owner slot is cleared in SHOW, the next edge SHALL select next-owner with counter 0, or enter IDLE if no slot is valid.
REQ-023 An accepted write to slot 0 while in SHOW with owner != 0 SHALL preempt: the next edge sets owner 0, counter 0. Slot 0 is the alert slot.
REQ-024 Preemption SHALL take priority over hold expiry and over owner-clear rotation in the same cycle.
REQ-025 out_val, out_src, out_blank and rot SHALL be registered and reflect the FSM and owner state committed at the same edge.
REQ-026 An accepted write to the current owner slot SHALL appear on out_val two edges after the accept edge, without restarting the counter.
REQ-027 rot SHALL be high for exactly one cycle after any edge where owner changes value or IDLE->SHOW occurs; it SHALL stay low when owner is re-selected unchanged.
REQ-028 In IDLE, out_blank SHALL be 1; out_val and out_src SHALL hold their last values.
REQ-029 The hold counter SHALL never exceed HOLD-1. Wrap SHALL be modulo-4 on the owner index only.

Reset
REQ-030 On rst_n low, the block SHALL set: all slot valid = 0, slot values = 16'h0000, FSM = IDLE, owner = 3 (so the first search starts at slot 0), counter = 0, out_val = 16'h0000, out_src = 2'd0, out_blank = 1, rot = 0, wr_ready = 0.
REQ-031 Reset asserted mid-SHOW SHALL force the reset values immediately, independent of clk.

Verification (HOLD=4)
REQ-032 Write 16'h1234 to slot 2 after reset -> out_val=16'h1234, out_src=2, out_blank=0 and one rot pulse, two edges after accept.
REQ-033 Slots 1=16'hAAAA and 3=16'hBBBB valid -> out_val alternates AAAA/BBBB every 4 cycles, with a rot pulse at each change.
REQ-034 Only slot 1 valid for 12 cycles -> out_val stays 16'hAAAA, no rot after the initial pulse.
REQ-035 Owner is slot 3, then write slot 0=16'hDEAD at counter=1 -> owner 0, out_val=16'hDEAD, counter restarted; the same cycle as hold expiry still gives slot 0.
REQ-036 clr on the sole valid owner -> IDLE, out_blank=1, out_val unchanged. Same-cycle clr and write on one slot -> slot stays valid with the new data.
REQ-037 rst_n pulsed low mid-SHOW -> all outputs at REQ-030 values asynchronously; wr_ready returns high one edge after release.
